// File: rtl/multi_mode_ping_pong_counter_pkg.sv
// Shared constants for the multi-mode ping-pong counter: motion modes and direction encoding.
package mmppc_pkg;

    localparam logic [1:0] MODE_PINGPONG = 2'b00;
    localparam logic [1:0] MODE_SATURATE = 2'b01;
    localparam logic [1:0] MODE_WRAP     = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/multi_mode_ping_pong_counter_if.sv
// Control/status bundle of the counter: the master drives bounds and commands, the slave reports the count.
interface mmppc_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              enable;
    logic              flip;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  min;
    logic [WIDTH-1:0]  max;
    logic [STEP_W-1:0] step;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  out;
    logic              direction;
    logic              limit;
    logic              range_err;

    modport master (
        output enable, flip, load, load_val, min, max, step, mode,
        input  out, direction, limit, range_err
    );

    modport slave (
        input  enable, flip, load, load_val, min, max, step, mode,
        output out, direction, limit, range_err
    );
endinterface

// File: rtl/multi_mode_ping_pong_counter_step_unit.sv
// Combinational next-count calculation for one enabled step in the selected motion mode.
module mmppc_step_unit
    import mmppc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  i_out,
    input  logic              i_direction,
    input  logic [STEP_W-1:0] i_step,
    input  logic [WIDTH-1:0]  i_min,
    input  logic [WIDTH-1:0]  i_max,
    input  logic [1:0]        i_mode,
    output logic [WIDTH-1:0]  o_next_out,
    output logic              o_next_dir,
    output logic              o_bound_hit
);
    // Two extra bits keep out+step and out-step free of overflow/underflow in signed compares.
    localparam int EW = WIDTH + 2;

    logic signed [EW-1:0] w_o, w_s, w_u, w_d, w_mn, w_mx, w_r;

    assign w_o  = $signed({2'b00, i_out});
    assign w_s  = $signed({{(EW-STEP_W){1'b0}}, i_step});
    assign w_mn = $signed({2'b00, i_min});
    assign w_mx = $signed({2'b00, i_max});
    assign w_u  = w_o + w_s;
    assign w_d  = w_o - w_s;

    always_comb begin
        w_r         = w_o;
        o_next_dir  = i_direction;
        o_bound_hit = 1'b0;
        case (i_mode)
            MODE_PINGPONG: begin
                if (i_direction == DIR_UP) begin
                    if (w_u <= w_mx) begin
                        w_r = w_u;
                    end else begin
                        w_r = w_mx - (w_u - w_mx);
                        if (w_r < w_mn) w_r = w_mn;
                        o_next_dir  = DIR_DOWN;
                        o_bound_hit = 1'b1;
                    end
                end else begin
                    if (w_d >= w_mn) begin
                        w_r = w_d;
                    end else begin
                        w_r = w_mn + (w_mn - w_d);
                        if (w_r > w_mx) w_r = w_mx;
                        o_next_dir  = DIR_UP;
                        o_bound_hit = 1'b1;
                    end
                end
            end
            MODE_SATURATE: begin
                // Pulse only when arriving at the bound, not while parked on it.
                if (i_direction == DIR_UP) begin
                    if (w_u >= w_mx) begin
                        w_r         = w_mx;
                        o_bound_hit = (w_o != w_mx);
                    end else begin
                        w_r = w_u;
                    end
                end else begin
                    if (w_d <= w_mn) begin
                        w_r         = w_mn;
                        o_bound_hit = (w_o != w_mn);
                    end else begin
                        w_r = w_d;
                    end
                end
            end
            MODE_WRAP: begin
                if (i_direction == DIR_UP) begin
                    if (w_u > w_mx) begin
                        w_r = w_mn + (w_u - w_mx - 1);
                        if (w_r > w_mx) w_r = w_mx;
                        o_bound_hit = 1'b1;
                    end else begin
                        w_r = w_u;
                    end
                end else begin
                    if (w_d < w_mn) begin
                        w_r = w_mx - (w_mn - w_d - 1);
                        if (w_r < w_mn) w_r = w_mn;
                        o_bound_hit = 1'b1;
                    end else begin
                        w_r = w_d;
                    end
                end
            end
            default: begin
                w_r = w_o;
            end
        endcase
    end

    assign o_next_out = w_r[WIDTH-1:0];

endmodule

// File: rtl/multi_mode_ping_pong_counter.sv
// Bounded up/down sequencer with ping-pong, saturate and wrap motion, load, limit pulse and range check.
module multi_mode_ping_pong_counter
    import mmppc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input logic clk,
    input logic rst_n,
    mmppc_if.slave bus
);
    logic [WIDTH-1:0] r_out, w_out_next;
    logic             r_dir, w_dir_next;
    logic             r_limit, w_limit_next;

    logic [WIDTH-1:0] w_load_clamped;
    logic             w_range_err;
    logic             w_dir_eff;
    logic [WIDTH-1:0] w_step_out;
    logic             w_step_dir;
    logic             w_step_hit;

    assign w_range_err    = (bus.min > bus.max) || (r_out < bus.min) || (r_out > bus.max);
    assign w_load_clamped = (bus.load_val < bus.min) ? bus.min :
                            (bus.load_val > bus.max) ? bus.max : bus.load_val;
    // A flip in the same cycle as a step moves in the freshly flipped direction.
    assign w_dir_eff      = bus.flip ? ~r_dir : r_dir;

    mmppc_step_unit #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_step (
        .i_out       (r_out),
        .i_direction (w_dir_eff),
        .i_step      (bus.step),
        .i_min       (bus.min),
        .i_max       (bus.max),
        .i_mode      (bus.mode),
        .o_next_out  (w_step_out),
        .o_next_dir  (w_step_dir),
        .o_bound_hit (w_step_hit)
    );

    always_comb begin
        w_out_next   = r_out;
        w_dir_next   = r_dir;
        w_limit_next = 1'b0;
        if (bus.load) begin
            if (bus.min <= bus.max) w_out_next = w_load_clamped;
        end else if (!w_range_err && bus.mode != MODE_HOLD) begin
            w_dir_next = w_dir_eff;
            if (bus.enable && bus.step != '0) begin
                w_out_next   = w_step_out;
                w_dir_next   = w_step_dir;
                w_limit_next = w_step_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= bus.min;
            r_dir   <= DIR_UP;
            r_limit <= 1'b0;
        end else begin
            r_out   <= w_out_next;
            r_dir   <= w_dir_next;
            r_limit <= w_limit_next;
        end
    end

    assign bus.out       = r_out;
    assign bus.direction = r_dir;
    assign bus.limit     = r_limit;
    assign bus.range_err = w_range_err;

endmodule

// File: tb/tb_multi_mode_ping_pong_counter.sv
// Directed vector bench for multi_mode_ping_pong_counter with hand-computed expectations.
module tb_multi_mode_ping_pong_counter;
    import mmppc_pkg::*;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic clk;
    logic rst_n;

    mmppc_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    multi_mode_ping_pong_counter #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       load;
        logic       en;
        logic       flip;
        logic [7:0] lv;
        logic [7:0] mn;
        logic [7:0] mx;
        logic [3:0] stp;
        logic [1:0] mode;
        logic [7:0] e_out;
        logic       e_dir;
        logic       e_lim;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic rst, logic load, logic en, logic flip, int lv, int mn, int mx,
                                int stp, logic [1:0] mode, int e_out, logic e_dir, logic e_lim, logic e_err);
        vec_t v;
        v.rst = rst; v.load = load; v.en = en; v.flip = flip;
        v.lv = 8'(lv); v.mn = 8'(mn); v.mx = 8'(mx); v.stp = 4'(stp); v.mode = mode;
        v.e_out = 8'(e_out); v.e_dir = e_dir; v.e_lim = e_lim; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(string name, int idx, logic [7:0] e_out, logic e_dir, logic e_lim, logic e_err);
        checks++;
        if (bus.out !== e_out || bus.direction !== e_dir || bus.limit !== e_lim || bus.range_err !== e_err) begin
            errors++;
            $display("FAIL %s #%0d: got out=%0d dir=%0b limit=%0b err=%0b, expected out=%0d dir=%0b limit=%0b err=%0b",
                     name, idx, bus.out, bus.direction, bus.limit, bus.range_err, e_out, e_dir, e_lim, e_err);
        end else begin
            $display("%s #%0d: out=%0d dir=%0b limit=%0b err=%0b ok",
                     name, idx, bus.out, bus.direction, bus.limit, bus.range_err);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        rst_n        = ~v.rst;
        bus.load     = v.load;
        bus.enable   = v.en;
        bus.flip     = v.flip;
        bus.load_val = v.lv;
        bus.min      = v.mn;
        bus.max      = v.mx;
        bus.step     = v.stp;
        bus.mode     = v.mode;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load = 1'b0; bus.enable = 1'b0; bus.flip = 1'b0;
        bus.load_val = '0; bus.min = 8'd3; bus.max = 8'd10;
        bus.step = '0; bus.mode = MODE_PINGPONG;

        //            rst load en flip lv mn mx stp mode           out dir lim err
        vecs.push_back(mk(1, 0, 0, 0,  0,  3, 10, 0, MODE_PINGPONG,  3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  9,  3, 10, 0, MODE_PINGPONG,  3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  0, 10, 0, MODE_PINGPONG,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 10, 3, MODE_PINGPONG,  3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 10, 3, MODE_PINGPONG,  6, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 10, 3, MODE_PINGPONG,  9, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 10, 3, MODE_PINGPONG,  8, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 10, 3, MODE_PINGPONG,  5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 10, 3, MODE_PINGPONG,  2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 10, 3, MODE_PINGPONG,  1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 10, 3, MODE_PINGPONG,  4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 10, 3, MODE_PINGPONG,  7, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0,  0,  3, 10, 3, MODE_PINGPONG,  3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  2,  9, 3, MODE_WRAP,      2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  2,  9, 3, MODE_WRAP,      5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  2,  9, 3, MODE_WRAP,      8, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  2,  9, 3, MODE_WRAP,      3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  2,  9, 3, MODE_WRAP,      6, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  2,  9, 3, MODE_WRAP,      9, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  2,  9, 3, MODE_WRAP,      4, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  0, 12, 5, MODE_SATURATE,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 12, 5, MODE_SATURATE,  5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 12, 5, MODE_SATURATE, 10, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 12, 5, MODE_SATURATE, 12, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 12, 5, MODE_SATURATE, 12, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1,  0,  0, 12, 5, MODE_SATURATE,  7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  0, 12, 5, MODE_SATURATE,  7, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  4,  0, 15, 5, MODE_SATURATE,  4, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 20,  0, 15, 5, MODE_SATURATE, 15, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  7,  0, 15, 5, MODE_SATURATE,  7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 10,  5, 3, MODE_PINGPONG,  7, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 10,  5, 3, MODE_PINGPONG,  7, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1,  0, 10,  5, 3, MODE_PINGPONG,  7, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  2, 10,  5, 3, MODE_PINGPONG,  7, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0,  8, 15, 3, MODE_PINGPONG,  7, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1,  0,  0, 15, 3, MODE_HOLD,      7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  0, 15, 3, MODE_HOLD,      7, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  3,  7,  7, 2, MODE_PINGPONG,  7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  7,  7, 2, MODE_PINGPONG,  7, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  7,  7, 2, MODE_PINGPONG,  7, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  7,  7, 2, MODE_PINGPONG,  7, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  1,  5, 15, 0, MODE_PINGPONG,  5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1,  0,  5, 15, 0, MODE_PINGPONG,  5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  5,  6, 4, MODE_PINGPONG,  5, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  3,  2,  9, 3, MODE_WRAP,      3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  2,  9, 3, MODE_WRAP,      8, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  2,  9, 5, MODE_SATURATE,  3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  2,  9, 5, MODE_SATURATE,  2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0,  2,  9, 5, MODE_SATURATE,  2, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check("vec", i, vecs[i].e_out, vecs[i].e_dir, vecs[i].e_lim, vecs[i].e_err);
        end

        // Hand sequence: reset held over several edges, then a pulse must last exactly one cycle.
        @(negedge clk);
        rst_n = 1'b0; bus.load = 1'b0; bus.enable = 1'b1; bus.flip = 1'b0;
        bus.min = 8'd4; bus.max = 8'd6; bus.step = 4'd2; bus.mode = MODE_PINGPONG;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("hold_reset", k, 8'd4, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("seq_step", 0, 8'd6, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("seq_reflect", 0, 8'd4, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.enable = 1'b0;
        @(posedge clk); #1;
        check("seq_pulse_end", 0, 8'd4, 1'b0, 1'b0, 1'b0);
        // Shrinking max below the held count raises range_err immediately, without a clock.
        @(negedge clk);
        bus.max = 8'd3;
        #1;
        check("seq_bound_shrink", 0, 8'd4, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_mode_ping_pong_counter.md
Name: multi_mode_ping_pong_counter

Overview:
- Parametrised successor of the 4-bit ping-pong counter: WIDTH-bit counter bounded by run-time min/max, programmable step, and three motion modes (ping-pong, saturate, wrap).
- Adds synchronous load, boundary/limit pulse, and range-error flag.
- Used as a pattern/address sequencer in lab top levels; drives 7-seg and LED displays.

Parameters:
- WIDTH, 8, counter/bound/load width.
- STEP_W, 4, width of step input.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  advance counter by step this cycle
- flip  in  1  toggle direction this cycle
- load  in  1  load load_val
- load_val  in  WIDTH  value to load (clamped to [min,max])
- min  in  WIDTH  lower bound
- max  in  WIDTH  upper bound
- step  in  STEP_W  increment magnitude; 0 = no motion
- mode  in  2  00 PINGPONG, 01 SATURATE, 10 WRAP, 11 reserved (hold)
- out  out  WIDTH  registered count
- direction  out  1  registered; 1 = up, 0 = down
- limit  out  1  registered one-cycle pulse on bound reflect/clamp/wrap
- range_err  out  1  combinational: (min > max) | (out < min) | (out > max)

Behaviour:
- All state updates on posedge clk. Reset: out=min, direction=1, limit=0.
- Priority per cycle: rst_n=0 > load > range_err hold > mode=11 hold > flip/enable.
- load: out <= load_val clamped to [min,max]; direction unchanged; limit=0; flip/enable ignored that cycle. If min>max, load holds.
- range_err=1 (not loading): out/direction hold, limit=0.
- flip: direction <= ~direction. If enable is also high, the step uses the new direction.
- enable=0 or step=0: out holds; flip still applies.
- Arithmetic is done in WIDTH+2 bits (signed-safe). u = out+step, d = out-step.
- PINGPONG, up:
  - u <= max: out=u.
  - Otherwise: out = max-(u-max), clamped to >= min; direction=0; limit=1.
- PINGPONG, down: mirror image. If d < min: out = min+(min-d), clamped to <= max; direction=1; limit=1.
- SATURATE: out = min(u,max) or max(d,min). limit=1 only on the cycle the bound is newly reached or clamped. Direction is never changed by hitting a bound.
- WRAP, up: if u > max, out = min+(u-max-1), clamped to <= max; limit=1. Direction unchanged.
- WRAP, down: if d < min, out = max-(min-d-1), clamped to >= min; limit=1.
- min==max: out stays at min. In PINGPONG, direction still reflects and limit pulses on every enabled step.
- limit is 0 on any cycle without a bound event.
- Bounds may change at run time. They are evaluated every cycle, with no latching.

Decomposition:
- Package mmppc_pkg:
  - mode localparams MODE_PINGPONG=2'b00, MODE_SATURATE=2'b01, MODE_WRAP=2'b10, MODE_HOLD=2'b11.
  - Direction constants DIR_UP=1, DIR_DOWN=0.
- Sub-module mmppc_step_unit (combinational):
  - inputs: out, direction, step, min, max, mode.
  - outputs: next_out, next_dir, bound_hit.
- The top holds the registers, load clamp, priority logic and range_err.

Test Plan:
- Reset: min=3, max=10, rst_n low 1 cycle -> out=3, direction=1, limit=0. Reset mid-count at out=7 -> out=3 next edge.
- PINGPONG, min=0, max=10, step=3, enable=1 from 0 -> out 3,6,9,8 (dir=0, limit=1),5,2,1 (dir=1, limit=1),4.
- WRAP, min=2, max=9, step=3 from 2 -> 5,8,3 (limit=1),6,9,4 (limit=1); direction stays 1.
- SATURATE, min=0, max=12, step=5 from 0 -> 5,10,12 (limit=1),12 (limit=0). flip+enable -> direction=0, out=7.
- Load priority: out=4, max=15, load=1, load_val=20, flip=1, enable=1 -> out=15, direction unchanged, limit=0.
- Range error: min=10, max=5, enable=1, out=7 -> range_err=1, out holds 7 for 3 cycles. mode=11 with valid range -> out holds.
